// File: rtl/addr_sweep_gen.sv
// ---------------------------------------------------------------------------
// addr_sweep_gen
//
// Programmable address sweep generator. It sits between the memory/display
// controller and a RAM read port, and addr drives the RAM address directly.
// A load latches the sweep bounds, step and mode, then restarts the sweep.
// Each enabled cycle in RUN advances the address by one step. Four modes are
// supported: wrap up, wrap down, ping-pong and one-shot up. The wrap and done
// strobes are used for frame and refresh bookkeeping.
//
// Parameters:
//   ADDR_W  address width in bits (2..16)
//   STEP_W  width of the step input (1..ADDR_W)
//   DIV     advance divider (1..255); only used when ADDR_SEQ_PRESCALE_EN
//           is defined
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   load        in   latch configuration and (re)start the sweep
//   en          in   advance enable
//   start_addr  in   lower sweep bound (lo)
//   end_addr    in   upper sweep bound (hi)
//   step        in   address increment/decrement magnitude
//   mode        in   00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up
//   addr        out  current address (registered)
//   dir         out  current direction, 0 up / 1 down
//   wrap        out  one-cycle pulse on wrap or turn-around
//   done        out  sticky one-shot completion flag
//   busy        out  high while in RUN
//   cfg_err     out  sticky, last load had lo > hi or step == 0
//
// Optional feature macro: ADDR_SEQ_PRESCALE_EN
//   When this macro is defined, an 8-bit prescaler counts the enabled RUN
//   cycles. Only every DIV-th such cycle advances the address.
// ---------------------------------------------------------------------------
module addr_sweep_gen #(
  parameter int ADDR_W = 8,
  parameter int STEP_W = 4,
  parameter int DIV    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic              dir,
  output logic              wrap,
  output logic              done,
  output logic              busy,
  output logic              cfg_err
);

  // One extra bit holds every sum and difference. This lets the bound
  // compares see true carries and borrows instead of aliased values.
  localparam int EXT_W = ADDR_W + 1;

  // Stop elaboration if the parameters fall outside the range that the
  // extended-width arithmetic below was written for.
  if (ADDR_W < 2 || ADDR_W > 16 || STEP_W < 1 || STEP_W > ADDR_W ||
      DIV < 1 || DIV > 255) begin : g_badParam
    $error("addr_sweep_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                dir_q, dir_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic                cfgErr_q, cfgErr_d;
  logic [ADDR_W-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0]   hi_q, hi_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          mode_q, mode_d;

  logic                advTick;
  logic [EXT_W-1:0]    addrX, loX, hiX, stepX;
  logic [EXT_W-1:0]    sumX, diffX, floorX;
  logic                upFits, downFits;

  // The compares are done on zero-extended copies of the current address
  // and the latched configuration. upFits means one step up stays at or
  // below hi. downFits means one step down stays at or above lo. It is
  // written as addr >= lo + step so the subtraction can never borrow past
  // zero.
  always_comb begin
    addrX    = {1'b0, addr_q};
    loX      = {1'b0, lo_q};
    hiX      = {1'b0, hi_q};
    stepX    = {{(EXT_W-STEP_W){1'b0}}, step_q};
    sumX     = addrX + stepX;
    diffX    = addrX - stepX;
    floorX   = loX + stepX;
    upFits   = (sumX <= hiX);
    downFits = (addrX >= floorX);
  end

`ifdef ADDR_SEQ_PRESCALE_EN
  logic [7:0] presc_q, presc_d;

  // The prescaler counts only the cycles that could advance: RUN with en
  // high and no load. It fires and clears on the DIV-1 count. A load
  // restarts the count so that every new sweep starts from a clean
  // divider phase.
  always_comb begin
    presc_d = presc_q;
    advTick = 1'b0;
    if (load) begin
      presc_d = 8'd0;
    end else if (state_q == RUN && en) begin
      if (presc_q == 8'(DIV - 1)) begin
        advTick = 1'b1;
        presc_d = 8'd0;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  // Prescaler count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // With no prescaler, every enabled RUN cycle advances. A load always
  // wins over en, so no advance happens in a load cycle.
  always_comb begin
    advTick = (state_q == RUN) && en && !load;
  end
`endif

  // Next-state and next-output logic. By default everything holds and wrap
  // drops, so IDLE, DONE and ERR simply freeze the outputs. A load is
  // checked first in every state. It latches the configuration whether or
  // not it is valid, so the sticky cfg_err always describes the most
  // recent load.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    done_d   = done_q;
    cfgErr_d = cfgErr_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    step_d   = step_q;
    mode_d   = mode_q;

    if (load) begin
      lo_d   = start_addr;
      hi_d   = end_addr;
      step_d = step;
      mode_d = mode;
      if (start_addr > end_addr || step == '0) begin
        state_d  = ERR;
        cfgErr_d = 1'b1;
        addr_d   = start_addr;
      end else begin
        state_d  = RUN;
        done_d   = 1'b0;
        cfgErr_d = 1'b0;
        if (mode == MODE_DOWN) begin
          addr_d = end_addr;
          dir_d  = 1'b1;
        end else begin
          addr_d = start_addr;
          dir_d  = 1'b0;
        end
      end
    end else if (advTick) begin
      case (mode_q)
        MODE_UP: begin
          if (upFits) begin
            addr_d = sumX[ADDR_W-1:0];
          end else begin
            addr_d = lo_q;
            wrap_d = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (downFits) begin
            addr_d = diffX[ADDR_W-1:0];
          end else begin
            addr_d = hi_q;
            wrap_d = 1'b1;
          end
        end
        MODE_PP: begin
          if (!dir_q) begin
            if (upFits) begin
              addr_d = sumX[ADDR_W-1:0];
            end else begin
              dir_d  = 1'b1;
              wrap_d = 1'b1;
              addr_d = downFits ? diffX[ADDR_W-1:0] : lo_q;
            end
          end else begin
            if (downFits) begin
              addr_d = diffX[ADDR_W-1:0];
            end else begin
              dir_d  = 1'b0;
              wrap_d = 1'b1;
              addr_d = upFits ? sumX[ADDR_W-1:0] : hi_q;
            end
          end
        end
        MODE_ONE: begin
          if (upFits) begin
            addr_d = sumX[ADDR_W-1:0];
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            wrap_d  = 1'b1;
          end
        end
        default: begin
          addr_d = addr_q;
        end
      endcase
    end
  end

  // State, output and configuration registers. Reset returns everything to
  // zero and IDLE immediately, so a fresh load is needed before the
  // generator will sweep again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      dir_q    <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      cfgErr_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      step_q   <= '0;
      mode_q   <= MODE_UP;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dir_q    <= dir_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      cfgErr_q <= cfgErr_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      mode_q   <= mode_d;
    end
  end

  // All outputs come straight from registers. busy is a decode of the
  // registered state, so it has no combinational path from the inputs.
  always_comb begin
    addr    = addr_q;
    dir     = dir_q;
    wrap    = wrap_q;
    done    = done_q;
    busy    = (state_q == RUN);
    cfg_err = cfgErr_q;
  end

endmodule

// File: tb/tb_addr_sweep_gen.sv
// ---------------------------------------------------------------------------
// tb_addr_sweep_gen
//
// Directed bench for addr_sweep_gen with ADDR_W=8, STEP_W=4, DIV=1.
// Each table row describes one clock cycle: the inputs held during the cycle
// and the outputs expected just after the rising edge that ends it. Reset
// and the asynchronous mid-sweep reset are handled by hand-written sequences
// around the table.
// ---------------------------------------------------------------------------
module tb_addr_sweep_gen;

  logic       clk;
  logic       rst;
  logic       load;
  logic       en;
  logic [7:0] start_addr;
  logic [7:0] end_addr;
  logic [3:0] step;
  logic [1:0] mode;
  logic [7:0] addr;
  logic       dir;
  logic       wrap;
  logic       done;
  logic       busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       ld;
    logic       en;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] st;
    logic [1:0] md;
    logic [7:0] eAddr;
    logic       eDir;
    logic       eWrap;
    logic       eDone;
    logic       eBusy;
    logic       eErr;
  } vec_t;

  vec_t vecs[$];

  addr_sweep_gen #(
    .ADDR_W(8),
    .STEP_W(4),
    .DIV(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .en(en),
    .start_addr(start_addr),
    .end_addr(end_addr),
    .step(step),
    .mode(mode),
    .addr(addr),
    .dir(dir),
    .wrap(wrap),
    .done(done),
    .busy(busy),
    .cfg_err(cfg_err)
  );

  // Free-running 100 MHz style clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Builds one table row.
  function automatic vec_t mk(string name, logic ld, logic e, logic [7:0] lo,
                              logic [7:0] hi, logic [3:0] st, logic [1:0] md,
                              logic [7:0] eAddr, logic eDir, logic eWrap,
                              logic eDone, logic eBusy, logic eErr);
    vec_t v;
    v.name  = name;
    v.ld    = ld;
    v.en    = e;
    v.lo    = lo;
    v.hi    = hi;
    v.st    = st;
    v.md    = md;
    v.eAddr = eAddr;
    v.eDir  = eDir;
    v.eWrap = eWrap;
    v.eDone = eDone;
    v.eBusy = eBusy;
    v.eErr  = eErr;
    return v;
  endfunction

  // Drives the inputs of one row with blocking assignments.
  task automatic applyStimulus(input logic ld, input logic e, input logic [7:0] lo,
                               input logic [7:0] hi, input logic [3:0] st,
                               input logic [1:0] md);
    load       = ld;
    en         = e;
    start_addr = lo;
    end_addr   = hi;
    step       = st;
    mode       = md;
  endtask

  // Compares every output against its expected value. Each output counts
  // as one check.
  task automatic checkOutput(input string name, input logic [7:0] eAddr,
                             input logic eDir, input logic eWrap, input logic eDone,
                             input logic eBusy, input logic eErr);
    checks++;
    if (addr !== eAddr) begin
      errors++;
      $display("[TB] FAIL %s addr got %0h want %0h", name, addr, eAddr);
    end
    checks++;
    if (dir !== eDir) begin
      errors++;
      $display("[TB] FAIL %s dir got %0b want %0b", name, dir, eDir);
    end
    checks++;
    if (wrap !== eWrap) begin
      errors++;
      $display("[TB] FAIL %s wrap got %0b want %0b", name, wrap, eWrap);
    end
    checks++;
    if (done !== eDone) begin
      errors++;
      $display("[TB] FAIL %s done got %0b want %0b", name, done, eDone);
    end
    checks++;
    if (busy !== eBusy) begin
      errors++;
      $display("[TB] FAIL %s busy got %0b want %0b", name, busy, eBusy);
    end
    checks++;
    if (cfg_err !== eErr) begin
      errors++;
      $display("[TB] FAIL %s cfg_err got %0b want %0b", name, cfg_err, eErr);
    end
  endtask

  initial begin
    // Up-wrap over 10..13 with step 1. wrap is high only on the return to 10.
    vecs.push_back(mk("upLoad", 1, 0, 8'h10, 8'h13, 4'd1, 2'b00, 8'h10, 0, 0, 0, 1, 0));
    vecs.push_back(mk("upA1",   0, 1, 0, 0, 0, 0, 8'h11, 0, 0, 0, 1, 0));
    vecs.push_back(mk("upA2",   0, 1, 0, 0, 0, 0, 8'h12, 0, 0, 0, 1, 0));
    vecs.push_back(mk("upA3",   0, 1, 0, 0, 0, 0, 8'h13, 0, 0, 0, 1, 0));
    vecs.push_back(mk("upWrap", 0, 1, 0, 0, 0, 0, 8'h10, 0, 1, 0, 1, 0));
    vecs.push_back(mk("upA5",   0, 1, 0, 0, 0, 0, 8'h11, 0, 0, 0, 1, 0));
    vecs.push_back(mk("upHold", 0, 0, 0, 0, 0, 0, 8'h11, 0, 0, 0, 1, 0));
    // Down-wrap over 0..9 with step 4. 1 - 4 must not underflow.
    vecs.push_back(mk("dnLoad", 1, 0, 8'h00, 8'h09, 4'd4, 2'b01, 8'h09, 1, 0, 0, 1, 0));
    vecs.push_back(mk("dnA1",   0, 1, 0, 0, 0, 0, 8'h05, 1, 0, 0, 1, 0));
    vecs.push_back(mk("dnA2",   0, 1, 0, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0));
    vecs.push_back(mk("dnWrap", 0, 1, 0, 0, 0, 0, 8'h09, 1, 1, 0, 1, 0));
    vecs.push_back(mk("dnA4",   0, 1, 0, 0, 0, 0, 8'h05, 1, 0, 0, 1, 0));
    // Ping-pong over 2..6 with step 3, exercising both turn-around clamps.
    vecs.push_back(mk("ppLoad", 1, 0, 8'h02, 8'h06, 4'd3, 2'b10, 8'h02, 0, 0, 0, 1, 0));
    vecs.push_back(mk("ppA1",   0, 1, 0, 0, 0, 0, 8'h05, 0, 0, 0, 1, 0));
    vecs.push_back(mk("ppTurnD",0, 1, 0, 0, 0, 0, 8'h02, 1, 1, 0, 1, 0));
    vecs.push_back(mk("ppTurnU",0, 1, 0, 0, 0, 0, 8'h05, 0, 1, 0, 1, 0));
    // Invalid loads: lo > hi, then step == 0. en is ignored in ERR.
    vecs.push_back(mk("errLoHi",1, 0, 8'h20, 8'h10, 4'd1, 2'b00, 8'h20, 0, 0, 0, 0, 1));
    vecs.push_back(mk("errEn1", 0, 1, 0, 0, 0, 0, 8'h20, 0, 0, 0, 0, 1));
    vecs.push_back(mk("errEn2", 0, 1, 0, 0, 0, 0, 8'h20, 0, 0, 0, 0, 1));
    vecs.push_back(mk("errStep0",1,0, 8'h05, 8'h08, 4'd0, 2'b00, 8'h05, 0, 0, 0, 0, 1));
    // A valid load together with en clears cfg_err and does not advance.
    vecs.push_back(mk("ldAndEn",1, 1, 8'h30, 8'h33, 4'd1, 2'b00, 8'h30, 0, 0, 0, 1, 0));
    vecs.push_back(mk("ldEnA1", 0, 1, 0, 0, 0, 0, 8'h31, 0, 0, 0, 1, 0));
    // One-shot over F0..FF with step 8 must stop at F8, not overflow to 00.
    vecs.push_back(mk("osLoad", 1, 0, 8'hF0, 8'hFF, 4'd8, 2'b11, 8'hF0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("osA1",   0, 1, 0, 0, 0, 0, 8'hF8, 0, 0, 0, 1, 0));
    vecs.push_back(mk("osDone", 0, 1, 0, 0, 0, 0, 8'hF8, 0, 1, 1, 0, 0));
    vecs.push_back(mk("osHold1",0, 1, 0, 0, 0, 0, 8'hF8, 0, 0, 1, 0, 0));
    vecs.push_back(mk("osHold2",0, 1, 0, 0, 0, 0, 8'hF8, 0, 0, 1, 0, 0));
    vecs.push_back(mk("osHold3",0, 1, 0, 0, 0, 0, 8'hF8, 0, 0, 1, 0, 0));
    vecs.push_back(mk("osHold4",0, 1, 0, 0, 0, 0, 8'hF8, 0, 0, 1, 0, 0));
    // lo == hi: up-wrap pulses wrap on every advance, a load clears done.
    vecs.push_back(mk("eqUpLd", 1, 0, 8'h40, 8'h40, 4'd1, 2'b00, 8'h40, 0, 0, 0, 1, 0));
    vecs.push_back(mk("eqUp1",  0, 1, 0, 0, 0, 0, 8'h40, 0, 1, 0, 1, 0));
    vecs.push_back(mk("eqUp2",  0, 1, 0, 0, 0, 0, 8'h40, 0, 1, 0, 1, 0));
    // lo == hi: ping-pong toggles dir on every advance.
    vecs.push_back(mk("eqPpLd", 1, 0, 8'h40, 8'h40, 4'd1, 2'b10, 8'h40, 0, 0, 0, 1, 0));
    vecs.push_back(mk("eqPp1",  0, 1, 0, 0, 0, 0, 8'h40, 1, 1, 0, 1, 0));
    vecs.push_back(mk("eqPp2",  0, 1, 0, 0, 0, 0, 8'h40, 0, 1, 0, 1, 0));
    // lo == hi: one-shot finishes on the first advance.
    vecs.push_back(mk("eqOsLd", 1, 0, 8'h50, 8'h50, 4'd2, 2'b11, 8'h50, 0, 0, 0, 1, 0));
    vecs.push_back(mk("eqOs1",  0, 1, 0, 0, 0, 0, 8'h50, 0, 1, 1, 0, 0));
    // Up-wrap near the top of the range: F8 + 8 wraps to lo instead of 00.
    vecs.push_back(mk("topLd",  1, 0, 8'hF0, 8'hFF, 4'd8, 2'b00, 8'hF0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("topA1",  0, 1, 0, 0, 0, 0, 8'hF8, 0, 0, 0, 1, 0));
    vecs.push_back(mk("topWrap",0, 1, 0, 0, 0, 0, 8'hF0, 0, 1, 0, 1, 0));

    rst = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 4'd0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // An idle generator that was never loaded ignores en.
    applyStimulus(0, 1, 8'h00, 8'h00, 4'd0, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("idleEn", 8'h00, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].en, vecs[i].lo, vecs[i].hi, vecs[i].st, vecs[i].md);
      @(posedge clk);
      #1;
      checkOutput(vecs[i].name, vecs[i].eAddr, vecs[i].eDir, vecs[i].eWrap,
                  vecs[i].eDone, vecs[i].eBusy, vecs[i].eErr);
    end

    // Asynchronous reset in the middle of a sweep: bring addr to 12 and
    // raise rst between edges. The outputs must clear before the next edge.
    applyStimulus(1, 0, 8'h10, 8'h13, 4'd1, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("rsLoad", 8'h10, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 8'h00, 8'h00, 4'd0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rsA2", 8'h12, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rsAsync", 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // After reset the generator is IDLE, so en has no effect until a load.
    @(posedge clk);
    #1;
    checkOutput("rsIdle", 8'h00, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 4'd0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
